// File: rtl/extended_wire_pkg.sv
// Shared types and helpers for the extended wire-in bank: word width,
// frame FSM states and the data-width sizing functions.
package extended_wire_pkg;

    localparam int WORD_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        SKIP
    } frame_state_e;

    function automatic int calc_words(input int data_width);
        return data_width / WORD_WIDTH;
    endfunction

    function automatic bit width_ok(input int data_width);
        return (data_width >= WORD_WIDTH) && (data_width % WORD_WIDTH == 0);
    endfunction

endpackage

// File: rtl/extended_wire_channel.sv
// One channel of the bank: shadow register, immediate-apply flag, pending
// flag and the glitch-free live register with its change-detect update pulse.
module extended_wire_channel
    import extended_wire_pkg::*;
#(
    parameter int   DATA_WIDTH          = 64,
    parameter logic FORWARD_ALL_UPDATES = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  commit,
    input  logic [DATA_WIDTH-1:0] commit_data,
    input  logic                  commit_imm,
    input  logic                  pp_update,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  update,
    output logic                  pending
);

    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  imm_q, imm_d;
    logic                  pending_q, pending_d;
    logic                  update_q, update_d;
    logic                  apply;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the block can leave a latch behind.
        apply      = imm_q | pp_update;
        shadow_d   = commit ? commit_data : shadow_q;
        imm_d      = imm_q;
        pending_d  = pending_q;
        if (apply) begin
            imm_d     = 1'b0;
            pending_d = 1'b0;
        end
        // A commit on the apply edge wins: the new shadow stays pending.
        if (commit) begin
            imm_d     = commit_imm;
            pending_d = 1'b1;
        end
        data_out_d = apply ? shadow_q : data_out_q;
        update_d   = apply && (FORWARD_ALL_UPDATES || (data_out_q != shadow_q));
    end

    always_ff @(posedge clk) begin
        // NOTE: the shadow is reset along with the live value, so consumers
        // never see an unknown parameter before the first apply.
        if (rst) begin
            shadow_q   <= '0;
            data_out_q <= '0;
            imm_q      <= 1'b0;
            pending_q  <= 1'b0;
            update_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            shadow_q   <= shadow_d;
            data_out_q <= data_out_d;
            imm_q      <= imm_d;
            pending_q  <= pending_d;
            update_q   <= update_d;
        end
    end

    assign data_out = data_out_q;
    assign update   = update_q;
    assign pending  = pending_q;

endmodule

// File: rtl/extended_wire_bank.sv
// Multi-channel extended wire-in bank: frames 16-bit host words into wide
// per-channel shadows and applies them immediately or on the global strobe.
module extended_wire_bank
    import extended_wire_pkg::*;
#(
    parameter int          DATA_WIDTH          = 64,
    parameter int          NUM_CHANNELS        = 8,
    parameter logic [15:0] BASE_ADDRESS        = 16'h0000,
    parameter logic        FORWARD_ALL_UPDATES = 1'b0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [15:0]                        word_in,
    input  logic                               word_valid,
    input  logic                               frame_start,
    input  logic                               apply_immediately,
    input  logic                               pp_update,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic [NUM_CHANNELS-1:0]            update,
    output logic [NUM_CHANNELS-1:0]            pending,
    output logic                               frame_error
);

    localparam int WORDS = calc_words(DATA_WIDTH);
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

    if (!width_ok(DATA_WIDTH)) begin : g_bad_width
        $error("extended_wire_bank: DATA_WIDTH must be a multiple of 16 and at least 16");
    end
    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 256) begin : g_bad_channels
        $error("extended_wire_bank: NUM_CHANNELS must be 1..256");
    end

    frame_state_e          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic                  frame_error_q, frame_error_d;
    logic [15:0]           addr_offset;
    logic                  commit;

    // Wraps modulo 2^16, so addresses below the base land out of range.
    assign addr_offset = word_in - BASE_ADDRESS;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            asm_q         <= '0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            asm_q         <= asm_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        asm_d         = asm_q;
        frame_error_d = 1'b0;
        if (word_valid) begin
            if (state_q == IDLE || frame_start) begin
                // Address word; in DATA/SKIP this also aborts the open frame.
                frame_error_d = frame_start && (state_q != IDLE);
                cnt_d         = '0;
                if (addr_offset < 16'(NUM_CHANNELS)) begin
                    state_d = DATA;
                    idx_d   = addr_offset[IDX_W-1:0];
                end else begin
                    state_d = SKIP;
                end
            end else begin
                if (state_q == DATA) begin
                    asm_d[cnt_q*WORD_WIDTH +: WORD_WIDTH] = word_in;
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        commit = word_valid && !frame_start && (state_q == DATA) && (cnt_q == LAST_CNT);
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        extended_wire_channel #(
            .DATA_WIDTH          (DATA_WIDTH),
            .FORWARD_ALL_UPDATES (FORWARD_ALL_UPDATES)
        ) u_channel (
            .clk         (clk),
            .rst         (rst),
            .commit      (commit && (idx_q == IDX_W'(i))),
            .commit_data (asm_d),
            .commit_imm  (apply_immediately),
            .pp_update   (pp_update),
            .data_out    (data_out[i*DATA_WIDTH +: DATA_WIDTH]),
            .update      (update[i]),
            .pending     (pending[i])
        );
    end

    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_extended_wire_bank.sv
// Self-checking bench: directed scenarios plus random framed traffic, with
// two DUTs (forward-all off/on) compared every cycle against a word-list model.
module tb_extended_wire_bank;

    localparam int          DW    = 64;
    localparam int          NC    = 8;
    localparam int          NW    = DW / 16;
    localparam int          VW    = NC * DW;
    localparam logic [15:0] BASE  = 16'h0010;

    typedef logic [VW-1:0] vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   word_in;
    logic          word_valid, frame_start, apply_immediately, pp_update;
    logic [VW-1:0] data_out0, data_out1;
    logic [NC-1:0] update0, update1, pending0, pending1;
    logic          frame_error0, frame_error1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    extended_wire_bank #(
        .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .BASE_ADDRESS(BASE), .FORWARD_ALL_UPDATES(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .frame_start(frame_start), .apply_immediately(apply_immediately),
        .pp_update(pp_update), .data_out(data_out0), .update(update0),
        .pending(pending0), .frame_error(frame_error0)
    );

    extended_wire_bank #(
        .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .BASE_ADDRESS(BASE), .FORWARD_ALL_UPDATES(1'b1)
    ) dut1 (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .frame_start(frame_start), .apply_immediately(apply_immediately),
        .pp_update(pp_update), .data_out(data_out1), .update(update1),
        .pending(pending1), .frame_error(frame_error1)
    );

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a frame is the list of words seen since its address.
    logic [DW-1:0] m_shadow [NC];
    logic [DW-1:0] m_live   [2][NC];
    bit            m_upd    [2][NC];
    bit            m_imm    [NC];
    bit            m_pend   [NC];
    bit            m_ferr;
    bit            m_in_frame;
    int            m_target;
    logic [15:0]   m_words  [$];

    task automatic model_step();
        bit          app [NC];
        logic [15:0] off;
        logic [DW-1:0] val;
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                m_shadow[c] = '0; m_imm[c] = 0; m_pend[c] = 0;
                for (int v = 0; v < 2; v++) begin
                    m_live[v][c] = '0; m_upd[v][c] = 0;
                end
            end
            m_ferr = 0; m_in_frame = 0; m_target = -1; m_words.delete();
            return;
        end
        for (int c = 0; c < NC; c++) begin
            app[c] = m_imm[c] || pp_update;
            for (int v = 0; v < 2; v++) begin
                m_upd[v][c] = app[c] && (v == 1 || m_live[v][c] != m_shadow[c]);
                if (app[c]) m_live[v][c] = m_shadow[c];
            end
            if (app[c]) begin
                m_imm[c]  = 0;
                m_pend[c] = 0;
            end
        end
        m_ferr = 0;
        if (word_valid) begin
            if (m_in_frame && frame_start) begin
                m_ferr     = 1;
                m_in_frame = 0;
            end
            if (!m_in_frame) begin
                off        = word_in - BASE;
                m_target   = (off < NC) ? int'(off) : -1;
                m_words.delete();
                m_in_frame = 1;
            end else begin
                m_words.push_back(word_in);
                if (m_words.size() == NW) begin
                    if (m_target >= 0) begin
                        for (int i = 0; i < NW; i++) val[i*16 +: 16] = m_words[i];
                        m_shadow[m_target] = val;
                        m_pend[m_target]   = 1;
                        m_imm[m_target]    = apply_immediately;
                    end
                    m_in_frame = 0;
                end
            end
        end
    endtask

    function automatic vec_t exp_dout(input int v);
        vec_t r = '0;
        for (int c = 0; c < NC; c++) r[c*DW +: DW] = m_live[v][c];
        return r;
    endfunction

    function automatic vec_t exp_upd(input int v);
        vec_t r = '0;
        for (int c = 0; c < NC; c++) r[c] = m_upd[v][c];
        return r;
    endfunction

    function automatic vec_t exp_pend();
        vec_t r = '0;
        for (int c = 0; c < NC; c++) r[c] = m_pend[c];
        return r;
    endfunction

    task automatic compare_all();
        check("data_out_fwd0",    data_out0,           exp_dout(0));
        check("data_out_fwd1",    data_out1,           exp_dout(1));
        check("update_fwd0",      vec_t'(update0),     exp_upd(0));
        check("update_fwd1",      vec_t'(update1),     exp_upd(1));
        check("pending_fwd0",     vec_t'(pending0),    exp_pend());
        check("pending_fwd1",     vec_t'(pending1),    exp_pend());
        check("frame_error_fwd0", vec_t'(frame_error0), vec_t'(m_ferr));
        check("frame_error_fwd1", vec_t'(frame_error1), vec_t'(m_ferr));
    endtask

    // Inputs change just after the falling edge; outputs are checked there too.
    task automatic cycle(input bit r, input bit v, input bit fs, input logic [15:0] w,
                         input bit imm, input bit pp);
        rst = r; word_valid = v; frame_start = fs; word_in = w;
        apply_immediately = imm; pp_update = pp;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [15:0] addr, input logic [DW-1:0] value,
                              input bit imm, input bit pp_last);
        cycle(1'b0, 1'b1, 1'b1, addr, 1'b0, 1'b0);
        for (int i = 0; i < NW; i++)
            cycle(1'b0, 1'b1, 1'b0, value[i*16 +: 16], imm, (i == NW - 1) ? pp_last : 1'b0);
    endtask

    function automatic logic [DW-1:0] ch(input vec_t d, input int c);
        return d[c*DW +: DW];
    endfunction

    localparam logic [DW-1:0] V_A = 64'h1111_2222_3333_4444;
    localparam logic [DW-1:0] V_B = 64'hDEAD_BEEF_0123_4567;
    localparam logic [DW-1:0] V_C = 64'h0F0F_A5A5_5A5A_F0F0;

    initial begin
        vec_t          expv;
        logic [15:0]   addr;
        logic [DW-1:0] rv;
        int            nwords;

        do_reset();
        check("reset_data_out", data_out0, '0);
        check("reset_pending",  vec_t'(pending0), '0);

        // Immediate frame to ch2.
        send_frame(16'h0012, V_A, 1'b1, 1'b0);
        check("imm_pending_after_e0", vec_t'(pending0[2]), vec_t'(1'b1));
        check("imm_live_unchanged_e0", vec_t'(ch(data_out0, 2)), '0);
        idle(1);
        check("imm_ch2_value", vec_t'(ch(data_out0, 2)), vec_t'(V_A));
        check("imm_update", vec_t'(update0), vec_t'(8'b0000_0100));
        idle(1);
        check("imm_update_one_cycle", vec_t'(update0), '0);
        check("imm_pending_cleared", vec_t'(pending0[2]), '0);

        // Deferred frame to ch2, applied by pp_update.
        do_reset();
        send_frame(16'h0012, V_A, 1'b0, 1'b0);
        idle(2);
        check("defer_pending", vec_t'(pending0), vec_t'(8'b0000_0100));
        check("defer_live_unchanged", data_out0, '0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        expv = '0; expv[2*DW +: DW] = V_A;
        check("pp_data_out", data_out0, expv);
        check("pp_update_fwd0", vec_t'(update0), vec_t'(8'b0000_0100));
        check("pp_update_fwd1", vec_t'(update1), vec_t'(8'hFF));

        // Identical value re-sent with immediate apply.
        send_frame(16'h0012, V_A, 1'b1, 1'b0);
        idle(1);
        check("same_value_fwd0", vec_t'(update0), '0);
        check("same_value_fwd1", vec_t'(update1), vec_t'(8'b0000_0100));

        // Out-of-range frame skipped, then a valid frame to ch1.
        do_reset();
        send_frame(16'h0030, V_B, 1'b1, 1'b0);
        send_frame(16'h0011, V_C, 1'b1, 1'b0);
        idle(1);
        expv = '0; expv[1*DW +: DW] = V_C;
        check("skip_then_ch1", data_out0, expv);

        // Abort a ch0 frame with a new address word for ch3.
        do_reset();
        cycle(1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 16'hAAAA, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 16'hBBBB, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 16'h0013, 1'b0, 1'b0);
        check("abort_frame_error", vec_t'(frame_error0), vec_t'(1'b1));
        for (int i = 0; i < NW; i++) begin
            cycle(1'b0, 1'b1, 1'b0, V_B[i*16 +: 16], 1'b1, 1'b0);
            if (i == 0) check("abort_error_one_cycle", vec_t'(frame_error0), '0);
        end
        idle(1);
        expv = '0; expv[3*DW +: DW] = V_B;
        check("abort_ch3_written_ch0_clean", data_out0, expv);

        // pp_update on the commit edge of an immediate frame to ch0.
        do_reset();
        send_frame(16'h0010, V_C, 1'b1, 1'b1);
        check("collide_old_applied", vec_t'(ch(data_out0, 0)), '0);
        check("collide_no_update", vec_t'(update0), '0);
        check("collide_still_pending", vec_t'(pending0[0]), vec_t'(1'b1));
        idle(1);
        check("collide_new_applied", vec_t'(ch(data_out0, 0)), vec_t'(V_C));
        check("collide_update", vec_t'(update0), vec_t'(8'b0000_0001));

        // Reset mid-frame discards the partial frame.
        cycle(1'b0, 1'b1, 1'b1, 16'h0014, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 16'h5678, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        check("rst_data_out", data_out0, '0);
        check("rst_pending", vec_t'(pending0), '0);
        check("rst_no_frame_error", vec_t'(frame_error0), '0);
        send_frame(16'h0014, V_A, 1'b1, 1'b0);
        idle(1);
        check("after_rst_ch4", vec_t'(ch(data_out0, 4)), vec_t'(V_A));

        // Random framed traffic: gaps, truncated frames, stray strobes, resets.
        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(0, 9) < 7) addr = BASE + 16'($urandom_range(0, NC - 1));
            else                          addr = 16'($urandom);
            rv     = {32'($urandom), 32'($urandom)};
            nwords = ($urandom_range(0, 9) == 0) ? $urandom_range(0, NW - 1) : NW;
            cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), addr, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0));
            for (int i = 0; i < nwords; i++) begin
                if ($urandom_range(0, 3) == 0)
                    cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'b0,
                          ($urandom_range(0, 7) == 0));
                cycle(1'b0, 1'b1, 1'b0, rv[i*16 +: 16], 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0));
            end
            if ($urandom_range(0, 99) == 0) cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
            if ($urandom_range(0, 4) == 0)  idle(2);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
